// File: rtl/alu_seq_core.sv
// Sequential MIPS ALU: private register file, valid/ready instruction and result handshakes,
// and a serial shifter that retires up to SHIFT_BPC bits per cycle.
module alu_seq_core #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 2,
  parameter int WRITEBACK = 1,
  parameter int SHIFT_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      flags,
  output logic            illegal
);
  localparam int AW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_BEQ, OP_BNE, OP_SLL, OP_SRL, OP_SRA, OP_ILL
  } op_e;

  function automatic logic add_ovf(input logic signed [XLEN-1:0] a, input logic signed [XLEN-1:0] b,
                                   input logic signed [XLEN-1:0] s);
    return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [XLEN-1:0] a, input logic signed [XLEN-1:0] b,
                                   input logic signed [XLEN-1:0] s);
    return (a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
  endfunction

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [AW-1:0]   amt_q, amt_d;
  logic [4:0]      dst_q, dst_d;
  logic            wen_q, wen_d, ill_q, ill_d, alive_q, alive_d;
  logic [2:0]      flg_q, flg_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic [5:0]  opc, fn;
  logic [4:0]  rs_a, rt_a, rd_a, shamt;
  logic [15:0] imm;
  logic [XLEN-1:0] imm_s, imm_z, rs_val, rt_val;

  assign opc   = instruction[31:26];
  assign rs_a  = instruction[25:21];
  assign rt_a  = instruction[20:16];
  assign rd_a  = instruction[15:11];
  assign shamt = instruction[10:6];
  assign fn    = instruction[5:0];
  assign imm   = instruction[15:0];
  assign imm_s = {{(XLEN-16){imm[15]}}, imm};
  assign imm_z = {{(XLEN-16){1'b0}}, imm};

  logic wb_fire, accept;
  assign out_valid = (state_q == DONE);
  assign in_ready  = alive_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign wb_fire   = (state_q == DONE) && out_ready && wen_q;
  assign result    = res_q;
  assign flags     = flg_q;
  assign illegal   = ill_q;

  // Next register-file image; host write overrides a same-cycle writeback.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
      if (wb_fire && dst_q == 5'(i)) rf_d[i] = res_q;
      if (wr_en && wr_addr == 5'(i)) rf_d[i] = wr_data;
    end
  end

  // Reading the next image gives the back-to-back bypass of the retiring writeback for free.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rs_a == 5'(i)) rs_val = rf_d[i];
      if (rt_a == 5'(i)) rt_val = rf_d[i];
    end
  end

  op_e             dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [AW-1:0]   dec_amt;
  logic [4:0]      dec_dst;
  logic            dec_wen;

  always_comb begin
    dec_op  = OP_ILL;
    dec_a   = rs_val;
    dec_b   = rt_val;
    dec_amt = '0;
    dec_dst = rd_a;
    dec_wen = 1'b1;
    if (opc == 6'h00) begin
      case (fn)
        6'h00: begin dec_op = OP_SLL; dec_amt = AW'(shamt); end
        6'h02: begin dec_op = OP_SRL; dec_amt = AW'(shamt); end
        6'h03: begin dec_op = OP_SRA; dec_amt = AW'(shamt); end
        6'h04: begin dec_op = OP_SLL; dec_amt = rs_val[AW-1:0]; end
        6'h06: begin dec_op = OP_SRL; dec_amt = rs_val[AW-1:0]; end
        6'h07: begin dec_op = OP_SRA; dec_amt = rs_val[AW-1:0]; end
        6'h20: dec_op = OP_ADD;
        6'h21: dec_op = OP_ADDU;
        6'h22: dec_op = OP_SUB;
        6'h23: dec_op = OP_SUBU;
        6'h24: dec_op = OP_AND;
        6'h25: dec_op = OP_OR;
        6'h26: dec_op = OP_XOR;
        6'h27: dec_op = OP_NOR;
        6'h2A: dec_op = OP_SLT;
        6'h2B: dec_op = OP_SLTU;
        default: ;
      endcase
    end else begin
      dec_dst = rt_a;
      case (opc)
        6'h04: begin dec_op = OP_BEQ; dec_wen = 1'b0; end
        6'h05: begin dec_op = OP_BNE; dec_wen = 1'b0; end
        6'h08: begin dec_op = OP_ADD;  dec_b = imm_s; end
        6'h09: begin dec_op = OP_ADDU; dec_b = imm_s; end
        6'h0A: begin dec_op = OP_SLT;  dec_b = imm_s; end
        6'h0B: begin dec_op = OP_SLTU; dec_b = imm_s; end
        6'h0C: begin dec_op = OP_AND;  dec_b = imm_z; end
        6'h0D: begin dec_op = OP_OR;   dec_b = imm_z; end
        6'h0E: begin dec_op = OP_XOR;  dec_b = imm_z; end
        6'h23, 6'h2B: begin dec_op = OP_ADDU; dec_b = imm_s; dec_wen = 1'b0; end
        default: ;
      endcase
    end
    if (dec_op == OP_ILL || WRITEBACK == 0) dec_wen = 1'b0;
  end

  logic signed [XLEN-1:0] a_s, b_s, res_s;
  logic [XLEN-1:0] sum, diff;
  logic [AW-1:0]   step, amt_left;
  logic            lt_s, lt_u;

  assign a_s      = a_q;
  assign b_s      = b_q;
  assign res_s    = res_q;
  assign sum      = a_q + b_q;
  assign diff     = a_q - b_q;
  assign lt_s     = a_s < b_s;
  assign lt_u     = a_q < b_q;
  assign step     = (amt_q < AW'(SHIFT_BPC)) ? amt_q : AW'(SHIFT_BPC);
  assign amt_left = amt_q - step;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    amt_d   = amt_q;
    dst_d   = dst_q;
    wen_d   = wen_q;
    res_d   = res_q;
    flg_d   = flg_q;
    ill_d   = ill_q;
    alive_d = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && out_ready) state_d = IDLE;
        if (accept) begin
          state_d = EXEC;
          op_d    = dec_op;
          a_d     = dec_a;
          b_d     = dec_b;
          amt_d   = dec_amt;
          dst_d   = dec_dst;
          wen_d   = dec_wen;
        end
      end
      EXEC: begin
        state_d = DONE;
        res_d   = '0;
        flg_d   = '0;
        ill_d   = 1'b0;
        case (op_q)
          OP_ADD:  begin res_d = sum;  flg_d[2] = add_ovf(a_s, b_s, sum); end
          OP_ADDU: res_d = sum;
          OP_SUB:  begin res_d = diff; flg_d[2] = sub_ovf(a_s, b_s, diff); end
          OP_SUBU: res_d = diff;
          OP_AND:  res_d = a_q & b_q;
          OP_OR:   res_d = a_q | b_q;
          OP_XOR:  res_d = a_q ^ b_q;
          OP_NOR:  res_d = ~(a_q | b_q);
          OP_SLT:  begin res_d = {{(XLEN-1){1'b0}}, lt_s}; flg_d[1] = lt_s; end
          OP_SLTU: begin res_d = {{(XLEN-1){1'b0}}, lt_u}; flg_d[1] = lt_u; end
          OP_BEQ:  flg_d[0] = (a_q == b_q);
          OP_BNE:  flg_d[0] = (a_q != b_q);
          OP_SLL, OP_SRL, OP_SRA: begin
            res_d = b_q;
            if (amt_q != '0) state_d = SHIFT;
          end
          default: ill_d = 1'b1;
        endcase
      end
      SHIFT: begin
        case (op_q)
          OP_SLL:  res_d = res_q << step;
          OP_SRL:  res_d = res_q >> step;
          default: res_d = res_s >>> step;
        endcase
        amt_d = amt_left;
        if (amt_left == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ILL;
      a_q     <= '0;
      b_q     <= '0;
      amt_q   <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      ill_q   <= 1'b0;
      alive_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      amt_q   <= amt_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      ill_q   <= ill_d;
      alive_q <= alive_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end
endmodule
